arcade_input_mapper: RTL

Parametrised control-input front end for arcade cores; replaces the per-core hand-written PS/2 decode, joystick OR and direction-swap logic in each top level. Decodes ps2_key events into latched key states for up to PLAYERS players. Merges them with per-player MiSTer joystick words and applies screen-rotation remapping. Adds per-player autofire and stretched, debounced coin pulses, and feeds the core's button inputs directly.

---
 rtl/arcade_input_mapper.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/arcade_input_mapper.sv
`default_nettype none
// ============================================================================
// Module   : arcade_input_mapper
// Brief    : PS/2 + joystick front end with rotation, autofire and coin pulses
// Revision : 1.0
// ============================================================================
module arcade_input_mapper #(
    parameter int PLAYERS      = 2,
    parameter int BUTTONS      = 4,
    parameter int COIN_PULSE   = 50000,
    parameter int COIN_HOLDOFF = 100000,
    parameter int AUTOFIRE_DIV = 250000
) (
    input  logic                           clk_sys,
    input  logic                           reset_n,
    input  logic [10:0]                    ps2_key,
    input  logic [16*PLAYERS-1:0]          joy_in,
    input  logic [1:0]                     rotate,
    input  logic [PLAYERS-1:0]             autofire_en,
    output logic [(4+BUTTONS)*PLAYERS-1:0] player_out,
    output logic [PLAYERS-1:0]             start,
    output logic [PLAYERS-1:0]             coin
);

    localparam int KP   = (PLAYERS < 2) ? PLAYERS : 2;
    localparam int KB   = (BUTTONS < 4) ? BUTTONS : 4;
    localparam int AFW  = $clog2(AUTOFIRE_DIV + 1);
    localparam int CMAX = (COIN_PULSE > COIN_HOLDOFF) ? COIN_PULSE : COIN_HOLDOFF;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [AFW-1:0] AF_LAST    = AFW'(AUTOFIRE_DIV - 1);
    localparam logic [CW-1:0]  PULSE_LAST = CW'(COIN_PULSE - 1);
    localparam logic [CW-1:0]  HOLD_LAST  = CW'((COIN_HOLDOFF > 0) ? COIN_HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_PULSE = 2'd1,
        C_HOLD  = 2'd2
    } coin_state_t;

    logic            tog_q;
    logic            armed_q;
    logic            w_event;
    logic            w_kv;
    logic            w_kp;
    logic [3:0]      w_ki;
    logic            w_unused_ext;
    logic [KB+3:0]   klat_q [KP];
    logic [1:0]      ksc_q  [KP];

    assign w_event      = armed_q && (ps2_key[10] != tog_q);
    assign w_unused_ext = ps2_key[8];

    // Index 0..3 = R,L,D,U; 4..7 = buttons; 8 = start; 9 = coin.
    always_comb begin
        w_kv = 1'b1;
        w_kp = 1'b0;
        w_ki = 4'd0;
        case (ps2_key[7:0])
            8'h75: w_ki = 4'd3;
            8'h72: w_ki = 4'd2;
            8'h6B: w_ki = 4'd1;
            8'h74: w_ki = 4'd0;
            8'h29: w_ki = 4'd4;
            8'h14: w_ki = 4'd5;
            8'h11: w_ki = 4'd6;
            8'h12: w_ki = 4'd7;
            8'h2D: begin w_kp = 1'b1; w_ki = 4'd3; end
            8'h2B: begin w_kp = 1'b1; w_ki = 4'd2; end
            8'h23: begin w_kp = 1'b1; w_ki = 4'd1; end
            8'h34: begin w_kp = 1'b1; w_ki = 4'd0; end
            8'h1C: begin w_kp = 1'b1; w_ki = 4'd4; end
            8'h1B: begin w_kp = 1'b1; w_ki = 4'd5; end
            8'h15: begin w_kp = 1'b1; w_ki = 4'd6; end
            8'h1D: begin w_kp = 1'b1; w_ki = 4'd7; end
            8'h16, 8'h05: w_ki = 4'd8;
            8'h1E, 8'h06: begin w_kp = 1'b1; w_ki = 4'd8; end
            8'h2E: w_ki = 4'd9;
            8'h36: begin w_kp = 1'b1; w_ki = 4'd9; end
            default: w_kv = 1'b0;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q   <= 1'b0;
            armed_q <= 1'b0;
            for (int p = 0; p < KP; p++) begin
                klat_q[p] <= '0;
                ksc_q[p]  <= '0;
            end
        end else begin
            tog_q   <= ps2_key[10];
            armed_q <= 1'b1;
            if (w_event && w_kv) begin
                for (int p = 0; p < KP; p++) begin
                    if (w_kp == 1'(p)) begin
                        for (int i = 0; i < KB + 4; i++) begin
                            if (w_ki == 4'(i)) klat_q[p][i] <= ps2_key[9];
                        end
                        if (w_ki == 4'd8) ksc_q[p][0] <= ps2_key[9];
                        if (w_ki == 4'd9) ksc_q[p][1] <= ps2_key[9];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [15:0]        w_joy;
        logic [BUTTONS+3:0] w_kraw;
        logic [1:0]         w_ksc;
        logic [BUTTONS+3:0] w_raw;
        logic               w_start_raw;
        logic               w_coin_raw;
        logic               w_unused_joy;
        logic [3:0]         w_dir;
        logic [BUTTONS-1:0] w_btn;
        logic               af_phase_q, af_phase_d, af_held_q;
        logic [AFW-1:0]     af_cnt_q, af_cnt_d;
        logic [BUTTONS+3:0] po_q;
        logic               st_q;
        coin_state_t        cst_q, cst_d;
        logic [CW-1:0]      ccnt_q, ccnt_d;
        logic               cprev_q;

        assign w_joy        = joy_in[16*p +: 16];
        assign w_unused_joy = ^w_joy;

        if (p < KP) begin : g_kbd
            assign w_kraw = (BUTTONS+4)'(klat_q[p]);
            assign w_ksc  = ksc_q[p];
        end else begin : g_nokbd
            assign w_kraw = '0;
            assign w_ksc  = '0;
        end

        assign w_raw       = w_kraw | w_joy[BUTTONS+3:0];
        assign w_start_raw = w_joy[BUTTONS+4] | w_ksc[0];
        assign w_coin_raw  = w_joy[BUTTONS+5] | w_ksc[1];

        // Direction vector is {U,D,L,R}.
        always_comb begin
            case (rotate)
                2'd1:    w_dir = {w_raw[1], w_raw[0], w_raw[2], w_raw[3]};
                2'd2:    w_dir = {w_raw[0], w_raw[1], w_raw[3], w_raw[2]};
                default: w_dir = w_raw[3:0];
            endcase
        end

        always_comb begin
            af_phase_d = 1'b0;
            af_cnt_d   = '0;
            w_btn      = w_raw[BUTTONS+3:4];
            if (autofire_en[p] && w_raw[4]) begin
                if (!af_held_q) begin
                    af_phase_d = 1'b1;
                end else if (af_cnt_q >= AF_LAST) begin
                    af_phase_d = ~af_phase_q;
                end else begin
                    af_phase_d = af_phase_q;
                    af_cnt_d   = af_cnt_q + AFW'(1);
                end
            end
            if (autofire_en[p]) w_btn[0] = af_phase_d;
        end

        always_comb begin
            cst_d  = cst_q;
            ccnt_d = ccnt_q;
            case (cst_q)
                C_IDLE: begin
                    if (w_coin_raw && !cprev_q) begin
                        cst_d  = C_PULSE;
                        ccnt_d = '0;
                    end
                end
                C_PULSE: begin
                    if (ccnt_q >= PULSE_LAST) begin
                        ccnt_d = '0;
                        cst_d  = (COIN_HOLDOFF == 0) ? C_IDLE : C_HOLD;
                    end else begin
                        ccnt_d = ccnt_q + CW'(1);
                    end
                end
                C_HOLD: begin
                    if (ccnt_q >= HOLD_LAST) begin
                        ccnt_d = '0;
                        cst_d  = C_IDLE;
                    end else begin
                        ccnt_d = ccnt_q + CW'(1);
                    end
                end
                default: begin
                    cst_d  = C_IDLE;
                    ccnt_d = '0;
                end
            endcase
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                af_phase_q <= 1'b0;
                af_cnt_q   <= '0;
                af_held_q  <= 1'b0;
                po_q       <= '0;
                st_q       <= 1'b0;
                cst_q      <= C_IDLE;
                ccnt_q     <= '0;
                cprev_q    <= 1'b0;
            end else begin
                af_phase_q <= af_phase_d;
                af_cnt_q   <= af_cnt_d;
                af_held_q  <= autofire_en[p] && w_raw[4];
                po_q       <= {w_btn, w_dir};
                st_q       <= w_start_raw;
                cst_q      <= cst_d;
                ccnt_q     <= ccnt_d;
                cprev_q    <= w_coin_raw;
            end
        end

        assign player_out[(BUTTONS+4)*p +: (BUTTONS+4)] = po_q;
        assign start[p] = st_q;
        assign coin[p]  = (cst_q == C_PULSE);
    end

endmodule
`default_nettype wire
